// File: rtl/multisim_server_pkg.sv
// multisim_server_pkg: word type and the multisim server call layer shared by every channel.
// The two server calls keep the multisim DPI signatures (start by name, get_data returning
// bit 0 = word valid). They are implemented here in SystemVerilog on top of a per-name scripted
// word store, so the HDL side can be built stand-alone. The other helpers fill and inspect that store.
package multisim_server_pkg;

    localparam int MULTISIM_WORD_W = 64;
    typedef bit [MULTISIM_WORD_W-1:0] multisim_word_t;

    multisim_word_t word_q[string][$];
    int             start_cnt[string];
    int             call_cnt[string];
    int             valid_cnt[string];

    function automatic int server_starts(input string name);
        return start_cnt.exists(name) ? start_cnt[name] : 0;
    endfunction

    function automatic int server_calls(input string name);
        return call_cnt.exists(name) ? call_cnt[name] : 0;
    endfunction

    function automatic int server_valids(input string name);
        return valid_cnt.exists(name) ? valid_cnt[name] : 0;
    endfunction

    function automatic int server_pending(input string name);
        return word_q.exists(name) ? word_q[name].size() : 0;
    endfunction

    function automatic void server_push(input string name, input multisim_word_t w);
        word_q[name].push_back(w);
    endfunction

    function automatic void multisim_server_start(input string name);
        start_cnt[name] = server_starts(name) + 1;
    endfunction

    function automatic int multisim_server_get_data(input string name, output multisim_word_t w);
        call_cnt[name] = server_calls(name) + 1;
        w = '0;
        if (server_pending(name) == 0) return 0;
        w = word_q[name].pop_front();
        valid_cnt[name] = server_valids(name) + 1;
        return 1;
    endfunction

endpackage

// File: rtl/multisim_server_channel.sv
// multisim_server_channel: one named server; polls 64-bit words, assembles beats, buffers them
// in a prefetch FIFO and presents them on a valid/ready stream.
// Ports: clk, rst (sync, active-high); index = numeric suffix of the server name;
// poll_en = poll enable; data_rdy/data_vld/data = output stream; beat_count = accepted beats.
module multisim_server_channel
    import multisim_server_pkg::*;
#(
    parameter int    WORDS_PER_BEAT = 1,
    parameter int    DEPTH          = 4,
    parameter int    POLL_INTERVAL  = 1,
    parameter string SERVER_PREFIX  = "cpu",
    localparam int   DATA_W         = MULTISIM_WORD_W * WORDS_PER_BEAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       index,
    input  logic              poll_en,
    input  logic              data_rdy,
    output logic              data_vld,
    output logic [DATA_W-1:0] data,
    output logic [31:0]       beat_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = POLL_INTERVAL > 1 ? $clog2(POLL_INTERVAL) : 1;
    localparam int WW = WORDS_PER_BEAT > 1 ? $clog2(WORDS_PER_BEAT) : 1;

    // Everything a valid DPI word can touch, so one poll updates it in a single step.
    typedef struct packed {
        logic [DEPTH-1:0][DATA_W-1:0]                    mem;
        logic [WORDS_PER_BEAT-1:0][MULTISIM_WORD_W-1:0] beat;
        logic [WW-1:0]                                   widx;
        logic [AW-1:0]                                   wr_ptr;
        logic [AW:0]                                     count;
    } fill_t;

    fill_t             s_q, s_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [31:0]       beat_cnt_q, beat_cnt_d;
    logic [DATA_W-1:0] hold_q;
    logic              started_q;
    string             name_q;
    logic              pop, space, poll;

    function automatic fill_t absorb(input fill_t s, input string name);
        multisim_word_t w;
        int             r;
        fill_t          n = s;
        r = multisim_server_get_data(name, w);
        if (r[0]) begin
            for (int k = 0; k < WORDS_PER_BEAT; k++)
                if (k == int'(s.widx)) n.beat[k] = w;
            if (int'(s.widx) == WORDS_PER_BEAT - 1) begin
                n.mem[s.wr_ptr] = n.beat;
                n.wr_ptr = s.wr_ptr + 1'b1;
                n.count = s.count + 1'b1;
                n.widx = '0;
            end else begin
                n.widx = s.widx + 1'b1;
            end
        end
        return n;
    endfunction

    assign data_vld   = s_q.count != '0;
    assign beat_count = beat_cnt_q;

    always_comb begin
        pop        = data_vld && data_rdy;
        // A same-cycle pop frees the slot the push would otherwise overflow into.
        space      = int'(s_q.count) < DEPTH || pop;
        poll       = started_q && !rst && poll_en && cnt_q == '0 && space;
        cnt_d      = !poll_en ? cnt_q : int'(cnt_q) == POLL_INTERVAL - 1 ? '0 : cnt_q + 1'b1;
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        beat_cnt_d = beat_cnt_q + 32'(pop);
        s_d        = s_q;
        s_d.count  = s_q.count - (AW+1)'(pop);
        // When empty, the last head beat stays on the bus.
        data       = data_vld ? s_q.mem[rd_ptr_q] : hold_q;
    end

    always_ff @(posedge clk) begin
        // Start runs once, on the first edge, and survives reset.
        if (started_q !== 1'b1) begin
            name_q <= $sformatf("%s_%0d", SERVER_PREFIX, index);
            multisim_server_start($sformatf("%s_%0d", SERVER_PREFIX, index));
        end
        started_q <= 1'b1;
        if (rst) begin
            s_q        <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            beat_cnt_q <= '0;
            hold_q     <= '0;
        end else begin
            s_q        <= poll ? absorb(s_d, name_q) : s_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            beat_cnt_q <= beat_cnt_d;
            hold_q     <= data;
        end
    end

endmodule

// File: rtl/multisim_server_multi.sv
// multisim_server_multi: NUM_CH independent multisim server channels behind one module.
// Ports: clk, rst (sync, active-high); base_index = name suffix of channel 0;
// poll_en = global poll enable; data_rdy/data_vld per channel; data = NUM_CH beats,
// channel i at [i*DATA_W +: DATA_W]; beat_count = NUM_CH 32-bit counters, channel i at [i*32 +: 32].
module multisim_server_multi
    import multisim_server_pkg::*;
#(
    parameter int    NUM_CH         = 4,
    parameter int    WORDS_PER_BEAT = 1,
    parameter int    DEPTH          = 4,
    parameter int    POLL_INTERVAL  = 1,
    parameter string SERVER_PREFIX  = "cpu",
    localparam int   DATA_W         = MULTISIM_WORD_W * WORDS_PER_BEAT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              base_index,
    input  logic                     poll_en,
    input  logic [NUM_CH-1:0]        data_rdy,
    output logic [NUM_CH-1:0]        data_vld,
    output logic [NUM_CH*DATA_W-1:0] data,
    output logic [NUM_CH*32-1:0]     beat_count
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        multisim_server_channel #(
            .WORDS_PER_BEAT(WORDS_PER_BEAT),
            .DEPTH         (DEPTH),
            .POLL_INTERVAL (POLL_INTERVAL),
            .SERVER_PREFIX (SERVER_PREFIX)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .index     (base_index + 32'(i)),
            .poll_en   (poll_en),
            .data_rdy  (data_rdy[i]),
            .data_vld  (data_vld[i]),
            .data      (data[i*DATA_W +: DATA_W]),
            .beat_count(beat_count[i*32 +: 32])
        );
    end

endmodule

// File: tb/tb_multisim_server_multi.sv
// tb_multisim_server_multi: directed vectors for a default 4-channel instance and a
// 2-word-beat, 3-cycle-interval single-channel instance.
module tb_multisim_server_multi;
    import multisim_server_pkg::*;

    logic         clk = 1'b0;
    logic         rst, poll_en;
    logic [3:0]   rdy, vld;
    logic [255:0] data;
    logic [127:0] beat;
    logic         rst2, poll_en2, rdy2, vld2;
    logic [127:0] data2;
    logic [31:0]  beat2;
    int           n_vec = 0;
    int           n_bad = 0;
    int           n;

    always #5 clk = ~clk;

    multisim_server_multi dut (
        .clk(clk), .rst(rst), .base_index(32'd8), .poll_en(poll_en),
        .data_rdy(rdy), .data_vld(vld), .data(data), .beat_count(beat)
    );

    multisim_server_multi #(
        .NUM_CH(1), .WORDS_PER_BEAT(2), .DEPTH(4), .POLL_INTERVAL(3), .SERVER_PREFIX("w")
    ) dut2 (
        .clk(clk), .rst(rst2), .base_index(32'd0), .poll_en(poll_en2),
        .data_rdy(rdy2), .data_vld(vld2), .data(data2), .beat_count(beat2)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int k = 1);
        repeat (k) @(negedge clk);
    endtask

    function automatic logic [63:0] d(input int ch);
        return data[ch*64 +: 64];
    endfunction

    function automatic logic [31:0] bc(input int ch);
        return beat[ch*32 +: 32];
    endfunction

    initial begin
        rst = 1; rst2 = 1; poll_en = 0; poll_en2 = 0; rdy = '0; rdy2 = 0;
        step(3);
        rst = 0; rst2 = 0;
        step();
        check("rst_vld", 128'(vld), 0);
        check("rst_data", data[127:0], 0);
        check("rst_beat", beat, 0);
        check("rst_vld2", 128'(vld2), 0);
        for (int i = 0; i < 4; i++)
            check($sformatf("start_cpu_%0d", 8 + i), 128'(server_starts($sformatf("cpu_%0d", 8 + i))), 1);

        // basic: two words on channel 0
        server_push("cpu_8", 64'hA);
        server_push("cpu_8", 64'hB);
        rdy = 4'hF; poll_en = 1;
        step();
        check("basic_vld1", 128'(vld), 128'b0001);
        check("basic_d1", 128'(d(0)), 128'hA);
        check("basic_bc1", 128'(bc(0)), 0);
        step();
        check("basic_vld2", 128'(vld), 128'b0001);
        check("basic_d2", 128'(d(0)), 128'hB);
        check("basic_bc2", 128'(bc(0)), 1);
        step();
        check("basic_vld3", 128'(vld), 0);
        check("basic_bc3", 128'(bc(0)), 2);
        check("basic_hold", 128'(d(0)), 128'hB);

        // backpressure on channel 1 with six words queued
        rdy = 4'b1101;
        for (int k = 1; k <= 6; k++) server_push("cpu_9", 64'(k));
        step(8);
        check("bp_valid_calls", 128'(server_valids("cpu_9")), 4);
        check("bp_vld", 128'(vld), 128'b0010);
        check("bp_d_stable", 128'(d(1)), 1);
        rdy = 4'hF;
        for (int k = 2; k <= 6; k++) begin
            step();
            if (k == 2) check("bp_resume", 128'(server_valids("cpu_9")), 5);
            check($sformatf("bp_d%0d", k), 128'(d(1)), 128'(k));
            check($sformatf("bp_vld%0d", k), 128'(vld[1]), 1);
        end
        step();
        check("bp_drained", 128'(vld), 0);
        check("bp_bc", 128'(bc(1)), 6);

        // independent streams on channels 2 and 3
        server_push("cpu_10", 64'h100);
        server_push("cpu_10", 64'h101);
        server_push("cpu_11", 64'h200);
        step();
        check("mc_vld1", 128'(vld), 128'b1100);
        check("mc_d2a", 128'(d(2)), 128'h100);
        check("mc_d3", 128'(d(3)), 128'h200);
        step();
        check("mc_vld2", 128'(vld), 128'b0100);
        check("mc_d2b", 128'(d(2)), 128'h101);
        check("mc_bc3", 128'(bc(3)), 1);
        step();
        check("mc_vld3", 128'(vld), 0);
        check("mc_bc2", 128'(bc(2)), 2);
        check("mc_bc0", 128'(bc(0)), 2);
        check("mc_bc1", 128'(bc(1)), 6);

        // poll throttle: one call every third cycle, counter holds while disabled
        poll_en2 = 1; rdy2 = 1;
        step();
        check("thr_e1", 128'(server_calls("w_0")), 1);
        step(2);
        check("thr_e3", 128'(server_calls("w_0")), 1);
        step();
        check("thr_e4", 128'(server_calls("w_0")), 2);
        step(3);
        check("thr_e7", 128'(server_calls("w_0")), 3);
        poll_en2 = 0;
        step(5);
        check("thr_off", 128'(server_calls("w_0")), 3);
        poll_en2 = 1;
        step(2);
        check("thr_hold", 128'(server_calls("w_0")), 3);
        step();
        check("thr_resume", 128'(server_calls("w_0")), 4);

        // wide beat: two words form one 128-bit beat, word 0 in the LSBs
        rst2 = 1; rdy2 = 0;
        step();
        rst2 = 0;
        server_push("w_0", 64'h1111);
        server_push("w_0", 64'h2222);
        n = 0;
        while (!vld2 && n < 20) begin step(); n++; end
        check("wide_wait", 128'(vld2), 1);
        check("wide_data", data2, {64'h2222, 64'h1111});
        check("wide_bc0", 128'(beat2), 0);
        rdy2 = 1;
        step();
        check("wide_bc1", 128'(beat2), 1);
        check("wide_empty", 128'(vld2), 0);

        // reset with two beats buffered and one word assembled
        rdy2 = 0;
        for (int k = 1; k <= 5; k++) server_push("w_0", 64'(k));
        n = 0;
        while (server_pending("w_0") != 0 && n < 40) begin step(); n++; end
        check("mid_fill", 128'(server_pending("w_0")), 0);
        check("mid_head", data2, {64'h2, 64'h1});
        rst2 = 1;
        step();
        check("mid_rst_vld", 128'(vld2), 0);
        check("mid_rst_bc", 128'(beat2), 0);
        check("mid_rst_data", data2, 0);
        rst2 = 0;
        server_push("w_0", 64'h6);
        server_push("w_0", 64'h7);
        n = 0;
        while (!vld2 && n < 20) begin step(); n++; end
        check("mid_fresh_vld", 128'(vld2), 1);
        check("mid_fresh_data", data2, {64'h7, 64'h6});
        check("mid_start_once", 128'(server_starts("w_0")), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
